// File: rtl/tpu_weight_pkg.sv
// Shared types and default sizing for the weight-FIFO loader.
package tpu_weight_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } wfc_state_e;

endpackage

// File: rtl/wfc_addr_gen.sv
// Weight-memory read sequencer: captures the base address and issues
// FIFO_DEPTH consecutive reads with a wrapping address.
module wfc_addr_gen
    import tpu_weight_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_ISSUE = CW'(FIFO_DEPTH);

    logic                  rd_en_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CW-1:0]         issue_cnt_reg;

    // issue_cnt_reg counts reads already presented on the bus, including the current one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_reg     <= 1'b0;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
        end else if (abort) begin
            rd_en_reg     <= 1'b0;
            addr_reg      <= '0;
            issue_cnt_reg <= '0;
        end else if (start) begin
            rd_en_reg     <= 1'b1;
            addr_reg      <= base_addr;
            issue_cnt_reg <= CW'(1);
        end else if (rd_en_reg) begin
            if (issue_cnt_reg == LAST_ISSUE) begin
                rd_en_reg     <= 1'b0;
                issue_cnt_reg <= '0;
            end else begin
                addr_reg      <= addr_reg + 1'b1;
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    assign rd_en   = rd_en_reg;
    assign rd_addr = addr_reg;

endmodule

// File: rtl/weight_fifo_ctrl.sv
// Controller that fills a weight FIFO from memory and drains it into the
// systolic array on request.
module weight_fifo_ctrl
    import tpu_weight_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic [ADDR_WIDTH-1:0]              load_base_addr,
    input  logic                               drain_req,
    input  logic                               flush,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_rd_addr,
    output logic                               fifo_en,
    output logic                               fifo_clr,
    output logic                               busy,
    output logic                               full,
    output logic                               drain_done,
    output logic                               cmd_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || DATA_WIDTH < 1) begin : g_param_check
        $error("weight_fifo_ctrl: FIFO_DEPTH must be 2..16 and DATA_WIDTH positive");
    end

    wfc_state_e    state_reg;
    logic [CW-1:0] count_reg;
    logic          fifo_en_reg;
    logic          fifo_clr_reg;
    logic          full_reg;
    logic          busy_reg;
    logic          drain_done_reg;
    logic          cmd_err_reg;
    logic          load_accept;

    assign load_accept = load_start && !flush && (state_reg == ST_IDLE);

    wfc_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .start     (load_accept),
        .abort     (flush),
        .base_addr (load_base_addr),
        .rd_en     (mem_rd_en),
        .rd_addr   (mem_rd_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            fifo_en_reg    <= 1'b0;
            fifo_clr_reg   <= 1'b0;
            full_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            drain_done_reg <= 1'b0;
            cmd_err_reg    <= 1'b0;
        end else begin
            fifo_clr_reg   <= 1'b0;
            drain_done_reg <= 1'b0;
            cmd_err_reg    <= 1'b0;
            if (flush) begin
                state_reg    <= ST_IDLE;
                count_reg    <= '0;
                fifo_en_reg  <= 1'b0;
                fifo_clr_reg <= 1'b1;
                full_reg     <= 1'b0;
                busy_reg     <= 1'b0;
            end else begin
                if (load_start && state_reg != ST_IDLE) begin
                    cmd_err_reg <= 1'b1;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (load_start) begin
                            state_reg    <= ST_LOAD;
                            fifo_clr_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            count_reg    <= '0;
                        end
                    end
                    // Read data lands one cycle after the strobe, so the shift follows it
                    ST_LOAD: begin
                        fifo_en_reg <= mem_rd_en;
                        if (mem_rd_en) begin
                            count_reg <= count_reg + 1'b1;
                        end
                        if (count_reg == DEPTH_C) begin
                            state_reg <= ST_FULL;
                            full_reg  <= 1'b1;
                        end
                    end
                    ST_FULL: begin
                        if (drain_req) begin
                            state_reg   <= ST_DRAIN;
                            full_reg    <= 1'b0;
                            fifo_en_reg <= 1'b1;
                            count_reg   <= count_reg - 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (count_reg == '0) begin
                            state_reg      <= ST_IDLE;
                            fifo_en_reg    <= 1'b0;
                            drain_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                        end else begin
                            fifo_en_reg <= 1'b1;
                            count_reg   <= count_reg - 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign fifo_en    = fifo_en_reg;
    assign fifo_clr   = fifo_clr_reg;
    assign busy       = busy_reg;
    assign full       = full_reg;
    assign drain_done = drain_done_reg;
    assign cmd_err    = cmd_err_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_weight_fifo_ctrl.sv
// Directed self-checking bench for weight_fifo_ctrl (FIFO_DEPTH=4, ADDR_WIDTH=8).
module tb_weight_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [7:0] load_base_addr;
    logic       drain_req;
    logic       flush;
    logic       mem_rd_en;
    logic [7:0] mem_rd_addr;
    logic       fifo_en;
    logic       fifo_clr;
    logic       busy;
    logic       full;
    logic       drain_done;
    logic       cmd_err;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    weight_fifo_ctrl #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .load_base_addr (load_base_addr),
        .drain_req      (drain_req),
        .flush          (flush),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .fifo_en        (fifo_en),
        .fifo_clr       (fifo_clr),
        .busy           (busy),
        .full           (full),
        .drain_done     (drain_done),
        .cmd_err        (cmd_err),
        .count          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int rd, input int fe, input int clr,
                             input int bsy, input int ful, input int cnt);
        chk({tag, ".mem_rd_en"}, 32'(mem_rd_en), 32'(rd));
        chk({tag, ".fifo_en"},   32'(fifo_en),   32'(fe));
        chk({tag, ".fifo_clr"},  32'(fifo_clr),  32'(clr));
        chk({tag, ".busy"},      32'(busy),      32'(bsy));
        chk({tag, ".full"},      32'(full),      32'(ful));
        chk({tag, ".count"},     32'(count),     32'(cnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk_state(tag, 0, 0, 0, 0, 0, 0);
        chk({tag, ".mem_rd_addr"}, 32'(mem_rd_addr), 32'h0);
        chk({tag, ".drain_done"},  32'(drain_done),  32'h0);
        chk({tag, ".cmd_err"},     32'(cmd_err),     32'h0);
    endtask

    // Accept at edge 0, then check cycles 1..6; leaves the DUT in FULL
    task automatic run_load(input logic [7:0] base, input string tag);
        logic [7:0] exp_addr;
        load_start     = 1'b1;
        load_base_addr = base;
        step();
        load_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            chk_state($sformatf("%s_c%0d", tag, c), (c <= 4) ? 1 : 0,
                      (c >= 2 && c <= 5) ? 1 : 0, (c == 1) ? 1 : 0, 1,
                      (c == 6) ? 1 : 0, (c == 1) ? 0 : ((c > 5) ? 4 : c - 1));
            if (c <= 4) begin
                exp_addr = base + 8'(c - 1);
                chk($sformatf("%s_c%0d.mem_rd_addr", tag, c), 32'(mem_rd_addr), 32'(exp_addr));
            end
        end
    endtask

    // Drain request from FULL, check cycles 1..6
    task automatic run_drain(input string tag);
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            if (d > 1) step();
            chk_state($sformatf("%s_d%0d", tag, d), 0, (d <= 4) ? 1 : 0, 0,
                      (d <= 4) ? 1 : 0, 0, (d <= 4) ? 4 - d : 0);
            chk($sformatf("%s_d%0d.drain_done", tag, d), 32'(drain_done), (d == 5) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        reset          = 1'b0;
        load_start     = 1'b0;
        load_base_addr = 8'h00;
        drain_req      = 1'b0;
        flush          = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();
        chk_all_zero("post_reset_idle");

        // Basic fill and drain
        run_load(8'h10, "basic");
        step();
        chk_state("basic_hold_full", 0, 0, 0, 1, 1, 4);
        run_drain("basic");

        // Address wrap, then flush out of FULL
        run_load(8'hFE, "wrap");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_state("wrap_flush", 0, 0, 1, 0, 0, 0);
        step();
        chk_state("wrap_flush_after", 0, 0, 0, 0, 0, 0);

        // load_start and drain_req while loading
        load_start     = 1'b1;
        load_base_addr = 8'h20;
        step();
        load_base_addr = 8'h55;
        drain_req      = 1'b1;
        step();
        load_start = 1'b0;
        drain_req  = 1'b0;
        chk("illegal_c2.cmd_err", 32'(cmd_err), 32'h1);
        chk("illegal_c2.mem_rd_addr", 32'(mem_rd_addr), 32'h21);
        chk_state("illegal_c2", 1, 1, 0, 1, 0, 1);
        step();
        chk("illegal_c3.cmd_err", 32'(cmd_err), 32'h0);
        chk("illegal_c3.mem_rd_addr", 32'(mem_rd_addr), 32'h22);
        chk_state("illegal_c3", 1, 1, 0, 1, 0, 2);
        step();
        chk("illegal_c4.mem_rd_addr", 32'(mem_rd_addr), 32'h23);
        chk_state("illegal_c4", 1, 1, 0, 1, 0, 3);
        step();
        chk_state("illegal_c5", 0, 1, 0, 1, 0, 4);
        step();
        chk_state("illegal_c6", 0, 0, 0, 1, 1, 4);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("illegal_full.cmd_err", 32'(cmd_err), 32'h1);
        chk_state("illegal_full", 0, 0, 0, 1, 1, 4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("illegal_flush.cmd_err", 32'(cmd_err), 32'h0);
        chk_state("illegal_flush", 0, 0, 1, 0, 0, 0);

        // Flush in the second LOAD cycle, then a clean reload
        load_start     = 1'b1;
        load_base_addr = 8'h30;
        step();
        load_start = 1'b0;
        step();
        chk_state("midflush_c2", 1, 1, 0, 1, 0, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_state("midflush_c3", 0, 0, 1, 0, 0, 0);
        run_load(8'h40, "reload");
        run_drain("reload");

        // drain_req in IDLE is ignored; flush beats load_start
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        chk_state("idle_drain", 0, 0, 0, 0, 0, 0);
        flush      = 1'b1;
        load_start = 1'b1;
        step();
        flush      = 1'b0;
        load_start = 1'b0;
        chk("flush_load.cmd_err", 32'(cmd_err), 32'h0);
        chk_state("flush_load", 0, 0, 1, 0, 0, 0);
        step();
        chk_state("flush_load_after", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset during DRAIN
        run_load(8'h80, "prereset");
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        step();
        chk_state("prereset_d2", 0, 1, 0, 1, 0, 2);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        reset = 1'b1;
        step();
        chk_all_zero("after_reset");
        run_load(8'h90, "after_reset_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_fifo_ctrl.md
WEIGHT_FIFO_CTRL -- requirements
Module: weight_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the weight width carried by the controlled FIFO stages; it does not change control timing.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the number of FIFO stages (legal range 2..16).
REQ-003 Parameter ADDR_WIDTH, default 8, SHALL set the weight-memory address width.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be asynchronous and active-low.
REQ-006 load_start  in  1  SHALL request one FIFO fill; it is sampled on a clock edge.
REQ-007 load_base_addr  in  ADDR_WIDTH  SHALL give the first weight address; it is captured with an accepted load_start.
REQ-008 drain_req  in  1  SHALL be a level request to shift the full FIFO into the array.
REQ-009 flush  in  1  SHALL be a synchronous abort and clear.
REQ-010 mem_rd_en / mem_rd_addr  out  1 / ADDR_WIDTH  SHALL be the weight-memory read strobe and address; read data is valid one cycle after mem_rd_en.
REQ-011 fifo_en / fifo_clr  out  1 / 1  SHALL drive the shift-enable and synchronous-clear inputs of every FIFO stage.
REQ-012 busy, full, drain_done, cmd_err  out  1 each  SHALL be status outputs; drain_done and cmd_err are one-cycle pulses.
REQ-013 count  out  $clog2(FIFO_DEPTH+1)  SHALL report the number of valid FIFO entries.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, FULL and DRAIN; all outputs are registered.
REQ-015 Accept timing: load_start=1 in IDLE at edge T SHALL cause the following:
- fifo_clr=1 in cycle T+1 only;
- mem_rd_en=1 in cycles T+1..T+FIFO_DEPTH, with mem_rd_addr=base+i (i=0..FIFO_DEPTH-1);
- busy=1 from T+1.
REQ-016 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-017 fifo_en SHALL equal mem_rd_en delayed by one cycle during LOAD, and count SHALL increment on each fifo_en edge.
REQ-018 full SHALL assert in the cycle after count reaches FIFO_DEPTH, and the state then SHALL be FULL.
REQ-019 In FULL, drain_req=1 at an edge SHALL cause:
- DRAIN state;
- full=0;
- fifo_en=1 for exactly FIFO_DEPTH cycles, with count decrementing once per cycle.
REQ-020 After the last drain shift, drain_done SHALL pulse for one cycle, the state returns to IDLE and busy=0.
REQ-021 drain_req outside FULL SHALL be ignored.
REQ-022 load_start outside IDLE SHALL be ignored and SHALL pulse cmd_err for one cycle.
REQ-023 flush=1 in any state SHALL cause, at the next edge:
- IDLE state;
- count=0;
- fifo_clr=1 for one cycle;
- mem_rd_en=0, fifo_en=0, full=0, busy=0.
REQ-024 flush SHALL win over a simultaneous load_start or drain_req, with no cmd_err raised.
REQ-025 fifo_en and fifo_clr SHALL never be high in the same cycle.

Reset
REQ-026 While reset=0, the state SHALL be IDLE and all outputs SHALL be 0, including count, mem_rd_addr and fifo_clr.
REQ-027 Reset assertion mid-LOAD or mid-DRAIN SHALL abandon the operation immediately; there is no resume.
REQ-028 After reset deassertion, the first accepted load_start SHALL follow REQ-015 exactly.

Structure
REQ-029 A shared package tpu_weight_pkg SHALL hold:
- the FSM state enumeration;
- the default FIFO_DEPTH, DATA_WIDTH and ADDR_WIDTH constants.
REQ-030 One sub-module, wfc_addr_gen, SHALL implement the following, with the FSM in the top level:
- base-address capture;
- the wrapping address counter;
- the read-issue counter.

Verification
REQ-031 Basic load/drain (FIFO_DEPTH=4): load_start=1 with base=0x10 at edge 0 -> the bench SHALL see:
- addresses 0x10..0x13 in cycles 1..4;
- fifo_en in cycles 2..5;
- full=1 in cycle 6.
Then drain_req -> fifo_en for 4 cycles, count 4->0, one drain_done pulse.
REQ-032 Address wrap: base=0xFE -> mem_rd_addr SHALL be 0xFE, 0xFF, 0x00, 0x01.
REQ-033 Illegal commands: load_start during LOAD -> cmd_err pulse with no address or count disturbance; drain_req during LOAD -> no effect.
REQ-034 Flush mid-operation: flush in the second LOAD cycle -> next cycle IDLE with count=0 and fifo_clr=1; a new load then proceeds normally.
REQ-035 Simultaneous events: flush together with load_start in IDLE -> no load starts and cmd_err=0.
REQ-036 Reset mid-operation: reset=0 during DRAIN -> all outputs 0 asynchronously, before the next clock edge; the state after release is IDLE.
